// File: rtl/gerenciador_pkg.sv
// gerenciador_pkg: one-hot activity encoding and saturating need arithmetic
package gerenciador_pkg;
  typedef enum logic [3:0] {
    IDLE       = 4'b0000,
    DORMINDO   = 4'b0001,
    COMENDO    = 4'b0010,
    DANDO_AULA = 4'b0100,
    MORTO      = 4'b1000
  } estado_t;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] max);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max}) ? max : s[31:0];
  endfunction
  function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
    return (a > b) ? a - b : '0;
  endfunction
endpackage

// File: rtl/gerenciador_estados_decodificador.sv
// decodificador_botoes: rising-edge detection with a combo window that merges b1+b2 into ev_ambos
module decodificador_botoes #(
  parameter int JANELA = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic b1,
  input  logic b2,
  output logic ev_b1,
  output logic ev_b2,
  output logic ev_ambos
);
  localparam int CW = JANELA > 0 ? $clog2(JANELA + 1) : 1;
  logic b1_q, b2_q, quem, e1, e2, outro;
  logic [CW-1:0] cnt;
  assign e1 = b1 & ~b1_q;
  assign e2 = b2 & ~b2_q;
  // quem remembers which button opened the window; only the other one can close it as a combo
  assign outro = quem ? e1 : e2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      b1_q <= 1'b0;
      b2_q <= 1'b0;
      quem <= 1'b0;
      cnt <= '0;
      ev_b1 <= 1'b0;
      ev_b2 <= 1'b0;
      ev_ambos <= 1'b0;
    end else begin
      b1_q <= b1;
      b2_q <= b2;
      ev_b1 <= 1'b0;
      ev_b2 <= 1'b0;
      ev_ambos <= 1'b0;
      if (cnt != '0) begin
        if (outro) begin
          ev_ambos <= 1'b1;
          cnt <= '0;
        end else if (cnt == CW'(1)) begin
          ev_b1 <= ~quem;
          ev_b2 <= quem;
          cnt <= '0;
        end else cnt <= cnt - 1'b1;
      end else if (e1 && e2) ev_ambos <= 1'b1;
      else if (e1 || e2) begin
        if (JANELA == 0) begin
          ev_b1 <= e1;
          ev_b2 <= e2;
        end else begin
          cnt <= CW'(JANELA);
          quem <= e2;
        end
      end
    end
  end
endmodule

// File: rtl/gerenciador_estados.sv
// gerenciador_estados: pet activity FSM with timed activities and hunger/sleep needs that can kill it
module gerenciador_estados #(
  parameter int NIVEL_W    = 4,
  parameter int TMR_W      = 8,
  parameter int PERIODO    = 4,
  parameter int DUR_COMER  = 10,
  parameter int DUR_DORMIR = 30,
  parameter int DUR_AULA   = 20,
  parameter int JANELA     = 3,
  parameter int DEC        = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               b1,
  input  logic               b2,
  input  logic               tick,
  output logic [3:0]         estado,
  output logic [NIVEL_W-1:0] fome,
  output logic [NIVEL_W-1:0] sono,
  output logic               morreu
);
  import gerenciador_pkg::*;
  localparam logic [NIVEL_W-1:0] NIVEL_MAX = '1;
  estado_t st, st_n;
  logic [TMR_W-1:0] timer, timer_n, presc, dur;
  logic [NIVEL_W-1:0] fome_n, sono_n;
  logic ev_b1, ev_b2, ev_ambos, passo, fim, morre;
  decodificador_botoes #(.JANELA(JANELA)) u_dec (
    .clk(clk),
    .rst(rst),
    .b1(b1),
    .b2(b2),
    .ev_b1(ev_b1),
    .ev_b2(ev_b2),
    .ev_ambos(ev_ambos)
  );
  function automatic logic [NIVEL_W-1:0] nivel_prox(input logic [NIVEL_W-1:0] v, input logic desce, input logic duplo);
    return desce ? NIVEL_W'(sat_sub(32'(v), 32'(DEC)))
                 : NIVEL_W'(sat_add(32'(v), duplo ? 32'd2 : 32'd1, 32'(NIVEL_MAX)));
  endfunction
  assign passo = tick && st != MORTO && presc == TMR_W'(PERIODO - 1);
  assign fim = tick && timer == TMR_W'(1);
  assign fome_n = passo ? nivel_prox(fome, st == COMENDO, st == DANDO_AULA) : fome;
  assign sono_n = passo ? nivel_prox(sono, st == DORMINDO, st == DANDO_AULA) : sono;
  assign morre = st != MORTO && (fome_n == NIVEL_MAX || sono_n == NIVEL_MAX);
  assign dur = st_n == COMENDO ? TMR_W'(DUR_COMER) : st_n == DORMINDO ? TMR_W'(DUR_DORMIR) : TMR_W'(DUR_AULA);
  always_comb begin
    st_n = st;
    case (st)
      IDLE:       st_n = ev_b1 ? COMENDO : ev_b2 ? DORMINDO : ev_ambos ? DANDO_AULA : IDLE;
      COMENDO:    st_n = (ev_b1 || fim) ? IDLE : COMENDO;
      DORMINDO:   st_n = (ev_b2 || fim) ? IDLE : DORMINDO;
      DANDO_AULA: st_n = (ev_ambos || fim) ? IDLE : DANDO_AULA;
      default:    st_n = st;
    endcase
    if (morre) st_n = MORTO;
  end
  // timer is cleared on every return to IDLE so a stale count never looks like a timeout
  always_comb begin
    timer_n = (st == MORTO || st_n == MORTO) ? timer
            : st_n == IDLE ? '0
            : st == IDLE ? dur
            : (tick && timer != '0) ? timer - 1'b1 : timer;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= IDLE;
      timer <= '0;
      presc <= '0;
      fome <= '0;
      sono <= '0;
    end else begin
      st <= st_n;
      timer <= timer_n;
      fome <= fome_n;
      sono <= sono_n;
      if (st != MORTO && tick) presc <= passo ? '0 : presc + 1'b1;
    end
  end
  assign estado = st;
  assign morreu = st == MORTO;
endmodule

// File: doc/gerenciador_estados.md
Name: gerenciador_estados

Overview:
- Parametrised next-generation pet state controller.
- Keeps the one-hot activity FSM: IDLE, DORMINDO, COMENDO, DANDO_AULA, MORTO.
- Adds:
  - button edge detection with a combo window for the both-button press;
  - timed activities that return to IDLE on their own;
  - internal hunger/sleep need counters that cause death on saturation.
- Sits between the synchronised button inputs and the display/LED logic.

Parameters:
NIVEL_W, 4, width of fome/sono counters; NIVEL_MAX = 2^NIVEL_W-1
TMR_W, 8, width of the activity timer and the prescaler
PERIODO, 4, tick pulses per need step (1..2^TMR_W-1)
DUR_COMER, 10, ticks in COMENDO before auto-exit; 0 = no timeout
DUR_DORMIR, 30, ticks in DORMINDO before auto-exit; 0 = no timeout
DUR_AULA, 20, ticks in DANDO_AULA before auto-exit; 0 = no timeout
JANELA, 3, combo window in clk cycles; 0 = only same-cycle edges combine
DEC, 2, need decrement per step while eating/sleeping

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
b1  in  1  button 1, already synchronised to clk, level
b2  in  1  button 2, already synchronised to clk, level
tick  in  1  one-clk-wide time-base pulse
estado  out  4  one-hot state: IDLE=0000, DORMINDO=0001, COMENDO=0010, DANDO_AULA=0100, MORTO=1000
fome  out  NIVEL_W  hunger level
sono  out  NIVEL_W  tiredness level
morreu  out  1  high iff estado==MORTO

Behaviour:
- Reset values (asynchronous): estado=IDLE, fome=0, sono=0, timer=0, prescaler=0, decoder idle, all edge registers=0.
- Edge detection: a rising edge is b(t)=1 and b(t-1)=0. Held levels produce no further events.
- Single-button edge opens the window; counter is loaded with JANELA.
  - Other button rises while the counter is nonzero -> ev_ambos pulse on the next cycle.
  - Counter reaches 0 with no other edge -> single event (ev_b1 or ev_b2) pulse on the next cycle.
  - Further edges of the same button inside the window are ignored.
  - Both edges in the same cycle -> ev_ambos on the next cycle, for any JANELA.
- Events are one-clk pulses. Latency is 1 cycle when JANELA=0 and JANELA+1 cycles otherwise. The FSM updates on the clk after the pulse.
- IDLE transitions: ev_b1 -> COMENDO; ev_b2 -> DORMINDO; ev_ambos -> DANDO_AULA.
- COMENDO exits to IDLE on ev_b1 or timeout. Other events are ignored.
- DORMINDO exits to IDLE on ev_b2 or timeout. Other events are ignored.
- DANDO_AULA exits to IDLE on ev_ambos or timeout. Other events are ignored.
- Timer:
  - Loaded with DUR_x on the entry edge.
  - Decrements on tick.
  - tick while timer==1 causes the exit to IDLE on that edge.
  - DUR_x=0 disables the timeout.
- Prescaler:
  - Counts ticks 0..PERIODO-1.
  - The wrap tick produces "passo" (internal, same cycle).
  - Prescaler is free-running in all states except MORTO.
- On passo, need updates by state:
  - IDLE: fome+1, sono+1.
  - COMENDO: fome-DEC (floor 0), sono+1.
  - DORMINDO: sono-DEC (floor 0), fome+1.
  - DANDO_AULA: fome+2, sono+2.
- Need arithmetic: all increments saturate at NIVEL_MAX. Computation is done in NIVEL_W+1 bits, then clamped.
- Death:
  - If the next value of fome or sono equals NIVEL_MAX, estado<=MORTO on the same edge.
  - Death overrides any event or timeout in that cycle.
- MORTO is sticky until rst. In MORTO, needs, timer and prescaler freeze and events are ignored.
- Simultaneous event and timeout in the same cycle give a single transition to IDLE.
- rst mid-window or mid-activity drops any pending event.

Decomposition:
- Package gerenciador_pkg holds:
  - the state localparams (IDLE, DORMINDO, COMENDO, DANDO_AULA, MORTO);
  - the function sat_add/sat_sub for NIVEL_W arithmetic.
- Sub-module decodificador_botoes (params JANELA; ports clk, rst, b1, b2 -> ev_b1, ev_b2, ev_ambos) holds the edge and combo-window logic.
- The FSM, timer, prescaler and needs stay in the top.

Test Plan (PERIODO=2, DEC=2, JANELA=3, DUR_COMER=4, NIVEL_W=4):
- b1 rises at cycle 10, b2 stays 0 -> ev_b1 at cycle 14; estado=0010 at cycle 15; 4 ticks later estado=0000.
- b1 rises at cycle 10, b2 rises at cycle 12 -> single ev_ambos at cycle 13, no ev_b1; estado=0100 at cycle 14.
- b1 and b2 rise in the same cycle with JANELA=0 -> ev_ambos next cycle -> DANDO_AULA.
- Idle with fome=13, sono=5, enter DANDO_AULA, then one passo -> fome clamps to 15, estado=1000 on the same edge, morreu=1. Further ticks and buttons change nothing.
- Eating with fome=1, one passo -> fome=0 (floor); b1 edge exits to IDLE before the timeout.
- rst pulsed asynchronously mid-window while in DORMINDO -> immediately estado=0000, fome=sono=0, no pending event emitted after rst deasserts.
